// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS data-memory dump engine
// MEM_DUMP_CHECKSUM_EN adds the CSUM state.
package mips_pkg;

   localparam int MEM_DUMP_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      CAPTURE = 3'd2,
      SEND    = 3'd3,
      DONE    = 3'd4
`ifdef MEM_DUMP_CHECKSUM_EN
      ,
      CSUM    = 3'd5
`endif
   } mem_dump_state_e;

endpackage

// File: rtl/mips_mem_dump_if.sv
// rtl/mips_mem_dump_if.sv - memory read port and output stream of the dump engine
// The master modport is the engine; the slave modport is the memory plus the consumer.
interface mips_mem_dump_if #(
   parameter int DATA_WIDTH = mips_pkg::MEM_DUMP_DATA_WIDTH,
   parameter int ADDR_WIDTH = 9
);
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic                  out_last;

   modport master (
      output mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last,
      input  mem_rd_data, out_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last,
      output mem_rd_data, out_ready
   );
endinterface

// File: rtl/mem_dump_csum.sv
// rtl/mem_dump_csum.sv - clear/accumulate register holding the wrapping sum of dumped words
// Only instantiated when MEM_DUMP_CHECKSUM_EN is defined.
module mem_dump_csum #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  acc,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] sum
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (acc) begin
         sum <= sum + din;
      end
   end
endmodule

// File: rtl/mips_mem_dump.sv
// rtl/mips_mem_dump.sv - walks a word range of DataMemory and streams each word out
// MEM_DUMP_CHECKSUM_EN appends a final beat carrying the wrapping sum of the words.
module mips_mem_dump
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = MEM_DUMP_DATA_WIDTH,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   output logic                  busy,
   output logic                  done,
   mips_mem_dump_if.master       bus
);
   mem_dump_state_e       state, state_n;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH:0]   remain;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  last_q;
   logic                  final_word;
   logic                  xfer;
   logic                  data_xfer;

   assign xfer       = (state == SEND) && bus.out_ready;
   assign final_word = (remain == (ADDR_WIDTH+1)'(1));

`ifdef MEM_DUMP_CHECKSUM_EN
   logic                  csum_phase;
   logic [DATA_WIDTH-1:0] sum;

   assign data_xfer = xfer && !csum_phase;

   mem_dump_csum #(.DATA_WIDTH(DATA_WIDTH)) u_csum (
      .clk   (clk),
      .rst   (rst),
      .clear (state == IDLE && start),
      .acc   (state == CAPTURE),
      .din   (bus.mem_rd_data),
      .sum   (sum)
   );
`else
   assign data_xfer = xfer;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = (word_count == '0) ? DONE : ISSUE;
         ISSUE:   state_n = CAPTURE;
         CAPTURE: state_n = SEND;
         SEND: begin
            if (xfer) begin
`ifdef MEM_DUMP_CHECKSUM_EN
               if (csum_phase)      state_n = DONE;
               else if (final_word) state_n = CSUM;
               else                 state_n = ISSUE;
`else
               state_n = final_word ? DONE : ISSUE;
`endif
            end
         end
`ifdef MEM_DUMP_CHECKSUM_EN
         CSUM:    state_n = SEND;
`endif
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Address and count advance only on a data-beat transfer, so a stall leaves them untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr   <= '0;
         remain <= '0;
         data_q <= '0;
         addr_q <= '0;
         last_q <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
         csum_phase <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr   <= base_addr;
                  remain <= word_count;
`ifdef MEM_DUMP_CHECKSUM_EN
                  csum_phase <= 1'b0;
`endif
               end
            end
            CAPTURE: begin
               data_q <= bus.mem_rd_data;
               addr_q <= addr;
`ifdef MEM_DUMP_CHECKSUM_EN
               last_q <= 1'b0;
`else
               last_q <= final_word;
`endif
            end
            SEND: begin
               if (data_xfer) begin
                  addr   <= addr + 1'b1;
                  remain <= remain - 1'b1;
               end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            CSUM: begin
               data_q     <= sum;
               addr_q     <= '0;
               last_q     <= 1'b1;
               csum_phase <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign busy          = (state != IDLE);
   assign done          = (state == DONE);
   assign bus.mem_rd_en = (state == ISSUE);
   assign bus.mem_addr  = (state == ISSUE) ? addr : '0;
   assign bus.out_valid = (state == SEND);
   assign bus.out_data  = data_q;
   assign bus.out_addr  = addr_q;
   assign bus.out_last  = last_q;
endmodule
